// File: rtl/imem_fetch_ctrl_pkg.sv
//==============================================================================
// Module  : imem_fetch_ctrl_pkg
// Purpose : Shared definitions for the instruction fetch buffer/refill
//           controller: 2-bit refill FSM state encodings and helpers that
//           derive the line-offset, index and tag widths from the
//           configuration parameters.
// Macros  : none
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package imem_fetch_ctrl_pkg;

    // Refill FSM state encodings
    localparam logic [1:0] IMEM_IDLE = 2'd0;
    localparam logic [1:0] IMEM_REQ  = 2'd1;
    localparam logic [1:0] IMEM_FILL = 2'd2;

    // Byte-offset width of one line: word index bits plus 2 byte bits
    function automatic int imem_off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    // Width of the word index inside a line
    function automatic int imem_idx_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Width of the line tag (address bits above the line offset)
    function automatic int imem_tag_w(input int addr_w, input int line_words);
        return addr_w - imem_off_w(line_words);
    endfunction

endpackage : imem_fetch_ctrl_pkg

`default_nettype wire

// File: rtl/imem_line_buf.sv
//==============================================================================
// Module  : imem_line_buf
// Purpose : Single-line instruction buffer. Holds LINE_WORDS x DATA_W words,
//           the line tag and a valid bit; performs the hit compare and the
//           word select for the current fetch address.
// Ports   : clk, rst            - clock, asynchronous active-high reset
//           i_wr_en/idx/data    - refill beat write into the data array
//           i_clr_valid         - invalidate the line (refill starting)
//           i_fill_done         - last beat written: load tag, set valid
//           i_fill_tag          - tag of the line being refilled
//           i_lookup_tag/idx    - tag and word index of the fetch address
//           o_hit               - line valid and tag matches
//           o_rdata             - selected word on hit, else 0
// Macros  : none
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_line_buf
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 28
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0]   i_wr_idx,
    input  logic [DATA_W-1:0]               i_wr_data,
    input  logic                            i_clr_valid,
    input  logic                            i_fill_done,
    input  logic [TAG_W-1:0]                i_fill_tag,
    input  logic [TAG_W-1:0]                i_lookup_tag,
    input  logic [$clog2(LINE_WORDS)-1:0]   i_lookup_idx,
    output logic                            o_hit,
    output logic [DATA_W-1:0]               o_rdata
);

    logic                r_valid;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_data [LINE_WORDS];
    logic                w_hit;

    // Tag/valid. Completion of a fill takes priority; a new refill cannot
    // start in the same cycle one finishes, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (i_fill_done) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
        end else if (i_clr_valid) begin
            r_valid <= 1'b0;
        end
    end

    // Data array needs no reset: it is only visible through a valid hit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign w_hit   = r_valid && (r_tag == i_lookup_tag);
    assign o_hit   = w_hit;
    assign o_rdata = w_hit ? r_data[i_lookup_idx] : '0;

endmodule : imem_line_buf

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
//==============================================================================
// Module  : imem_fetch_ctrl
// Purpose : Fetch-side instruction memory controller. A single-line fetch
//           buffer serves hits combinationally; a miss raises f_imem_stall
//           and runs a REQ/FILL refill of one full line from a beat-based
//           instruction memory. A refill is never aborted by a redirect;
//           the new fetch address is re-evaluated once the line is in.
// Ports   : clk, reset          - clock, asynchronous active-high reset
//           f_req, f_pc         - fetch request and byte address
//           f_instr             - instruction on hit, else 0
//           f_imem_stall        - f_req & ~hit (0 while reset is high)
//           mem_req, mem_addr   - refill request / line-aligned address
//           mem_ack             - request accepted (used only in REQ)
//           mem_rvalid/rdata    - refill beats, word 0 first (used in FILL)
//           perf_miss_cnt       - refills started (saturating)
//           perf_stall_cnt      - stalled cycles (saturating)
// Macros  : IMEM_PERF_EN - enables the performance counters; when
//           undefined both perf outputs are tied to 0 with no flops.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                f_req,
    input  logic [ADDR_W-1:0]   f_pc,
    output logic [DATA_W-1:0]   f_instr,
    output logic                f_imem_stall,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [31:0]         perf_miss_cnt,
    output logic [31:0]         perf_stall_cnt
);

    localparam int c_OFF_W = imem_off_w(LINE_WORDS);
    localparam int c_IDX_W = imem_idx_w(LINE_WORDS);
    localparam int c_TAG_W = imem_tag_w(ADDR_W, LINE_WORDS);

    localparam logic [c_IDX_W-1:0] c_LAST_BEAT = c_IDX_W'(LINE_WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_BEAT_ONE  = c_IDX_W'(1);

    // Fetch address decode
    logic [c_TAG_W-1:0]  w_tag;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_unused_pc_bits;

    assign w_tag            = f_pc[ADDR_W-1:c_OFF_W];
    assign w_idx            = f_pc[c_OFF_W-1:2];
    assign w_unused_pc_bits = ^f_pc[1:0];

    // Refill control
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_TAG_W-1:0]  r_miss_tag;
    logic [c_IDX_W-1:0]  r_beat_cnt;

    logic                w_hit;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_miss;
    logic                w_start_miss;
    logic                w_mem_req;
    logic                w_beat_wr;
    logic                w_fill_done;

    assign w_miss = f_req && !w_hit;

    //--------------------------------------------------------------------------
    // Line buffer
    //--------------------------------------------------------------------------
    imem_line_buf #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (c_TAG_W)
    ) u_line_buf (
        .clk          (clk),
        .rst          (reset),
        .i_wr_en      (w_beat_wr),
        .i_wr_idx     (r_beat_cnt),
        .i_wr_data    (mem_rdata),
        .i_clr_valid  (w_start_miss),
        .i_fill_done  (w_fill_done),
        .i_fill_tag   (r_miss_tag),
        .i_lookup_tag (w_tag),
        .i_lookup_idx (w_idx),
        .o_hit        (w_hit),
        .o_rdata      (w_rdata)
    );

    //--------------------------------------------------------------------------
    // Refill FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IMEM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // Refill FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IMEM_IDLE: begin
                if (w_miss) begin
                    w_next_state = IMEM_REQ;
                end
            end
            IMEM_REQ: begin
                if (mem_ack) begin
                    w_next_state = IMEM_FILL;
                end
            end
            IMEM_FILL: begin
                if (mem_rvalid && (r_beat_cnt == c_LAST_BEAT)) begin
                    w_next_state = IMEM_IDLE;
                end
            end
            default: begin
                w_next_state = IMEM_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Refill FSM: outputs. Handshake inputs are only looked at in the state
    // that owns them, so stray ack/rvalid pulses are ignored elsewhere.
    //--------------------------------------------------------------------------
    always_comb begin
        w_start_miss = 1'b0;
        w_mem_req    = 1'b0;
        w_beat_wr    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            IMEM_IDLE: begin
                w_start_miss = w_miss;
            end
            IMEM_REQ: begin
                w_mem_req = 1'b1;
            end
            IMEM_FILL: begin
                w_beat_wr   = mem_rvalid;
                w_fill_done = mem_rvalid && (r_beat_cnt == c_LAST_BEAT);
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Miss tag and beat counter. The counter wraps back to 0 on the last
    // beat by its own width, so it is ready for the next refill.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miss_tag <= '0;
            r_beat_cnt <= '0;
        end else if (w_start_miss) begin
            r_miss_tag <= w_tag;
            r_beat_cnt <= '0;
        end else if (w_beat_wr) begin
            r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
        end
    end

    //--------------------------------------------------------------------------
    // Fetch-side and memory-side outputs
    //--------------------------------------------------------------------------
    assign f_imem_stall = w_miss && !reset;
    assign f_instr      = reset ? '0 : w_rdata;
    assign mem_req      = w_mem_req;
    // Derived from the latched miss tag, so it is stable for the whole REQ
    // phase regardless of what f_pc does meanwhile.
    assign mem_addr     = {r_miss_tag, {c_OFF_W{1'b0}}};

    //--------------------------------------------------------------------------
    // Performance counters
    //--------------------------------------------------------------------------
`ifdef IMEM_PERF_EN
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_stall;

    // w_miss equals f_imem_stall whenever the counters are out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_miss  <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_start_miss && (r_perf_miss != 32'hFFFF_FFFF)) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
            if (w_miss && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_miss_cnt  = r_perf_miss;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_miss_cnt  = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule : imem_fetch_ctrl

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
//==============================================================================
// Module  : tb_imem_fetch_ctrl
// Purpose : Self-checking bench for imem_fetch_ctrl. Directed scenarios
//           (cold miss, hits, slow memory, redirect, reset mid-refill,
//           performance counters) followed by randomized fetch traffic,
//           all checked against a line-level reference model.
// Macros  : IMEM_PERF_EN - selects expected perf counter values
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_fetch_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;
`ifdef IMEM_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                f_req;
    logic [ADDR_W-1:0]   f_pc;
    logic [DATA_W-1:0]   f_instr;
    logic                f_imem_stall;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;
    logic [31:0]         perf_miss_cnt;
    logic [31:0]         perf_stall_cnt;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .f_req          (f_req),
        .f_pc           (f_pc),
        .f_instr        (f_instr),
        .f_imem_stall   (f_imem_stall),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .perf_miss_cnt  (perf_miss_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: contents of the one buffered line, plus event counts
    bit          m_valid = 1'b0;
    logic [31:0] m_line  = 32'h0;
    logic [31:0] m_data [LINE_WORDS];
    int unsigned m_misses = 0;
    int unsigned m_stalls = 0;

    // Instruction memory image: a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return pc & ~32'hF;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid && (line_of(pc) == m_line);
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
        logic [1:0] w;
        w = pc[3:2];
        return model_hit(pc) ? m_data[w] : 32'h0;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        base = 32'h100 + 32'(16 * $urandom_range(0, 5));
        if ($urandom_range(0, 7) == 0) base = base | 32'h8000_0000;
        return base + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic ack,
                         input logic rv, input logic [31:0] rd);
        f_req      = req;
        f_pc       = pc;
        mem_ack    = ack;
        mem_rvalid = rv;
        mem_rdata  = rd;
    endtask

    // Check one cycle's outputs against the model, then advance one clock.
    task automatic cyc(input string tag, input logic exp_mreq, input logic [31:0] exp_addr);
        logic exp_stall;
        exp_stall = f_req && !model_hit(f_pc);
        #1;
        check({tag, " stall"}, 32'(f_imem_stall), 32'(exp_stall));
        check({tag, " instr"}, f_instr, model_instr(f_pc));
        check({tag, " mem_req"}, 32'(mem_req), 32'(exp_mreq));
        if (exp_mreq) check({tag, " mem_addr"}, mem_addr, exp_addr);
        if (exp_stall) m_stalls++;
        @(negedge clk);
    endtask

    task automatic check_perf(input string tag);
        #1;
        check({tag, " perf_miss"}, perf_miss_cnt, PERF_EN ? 32'(m_misses) : 32'h0);
        check({tag, " perf_stall"}, perf_stall_cnt, PERF_EN ? 32'(m_stalls) : 32'h0);
    endtask

    // Reset pulse starting at a negedge; outputs checked while reset is high.
    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst stall", 32'(f_imem_stall), 32'h0);
        check("rst instr", f_instr, 32'h0);
        check("rst mem_req", 32'(mem_req), 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst perf_miss", perf_miss_cnt, 32'h0);
        check("rst perf_stall", perf_stall_cnt, 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        m_valid  = 1'b0;
        m_misses = 0;
        m_stalls = 0;
    endtask

    // One fetch of pc. On a miss, runs the full refill: ack after ack_dly
    // extra REQ cycles, min_gap..max_gap idle cycles before each beat,
    // optional redirect after beat redir_beat, optional reset after rst_beat.
    task automatic fetch(input logic [31:0] pc, input int ack_dly, input int min_gap,
                         input int max_gap, input bit rnd_req, input int redir_beat,
                         input logic [31:0] redir_pc, input int rst_beat);
        logic [31:0] cur_pc;
        logic [31:0] line;
        logic        rq;
        cur_pc = pc;
        if (model_hit(pc)) begin
            drive(1'b1, pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            cyc("hit", 1'b0, 32'h0);
            return;
        end
        line = line_of(pc);
        drive(1'b1, pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        cyc("miss", 1'b0, 32'h0);
        m_valid = 1'b0;
        m_misses++;
        for (int k = 0; k <= ack_dly; k++) begin
            rq = rnd_req ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(rq, cur_pc, 1'(k == ack_dly), 1'($urandom_range(0, 1)), $urandom);
            cyc("req", 1'b1, line);
        end
        for (int b = 0; b < LINE_WORDS; b++) begin
            int g;
            g = $urandom_range(min_gap, max_gap);
            for (int i = 0; i < g; i++) begin
                rq = rnd_req ? 1'($urandom_range(0, 1)) : 1'b1;
                drive(rq, cur_pc, 1'($urandom_range(0, 1)), 1'b0, $urandom);
                cyc("gap", 1'b0, 32'h0);
            end
            rq = rnd_req ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(rq, cur_pc, 1'($urandom_range(0, 1)), 1'b1, mem_word(line + 32'(4 * b)));
            cyc("beat", 1'b0, 32'h0);
            if (b == LINE_WORDS - 1) begin
                m_valid = 1'b1;
                m_line  = line;
                for (int i = 0; i < LINE_WORDS; i++) m_data[i] = mem_word(line + 32'(4 * i));
            end
            if (b == redir_beat) cur_pc = redir_pc;
            if (b == rst_beat) begin
                apply_reset();
                return;
            end
        end
    endtask

    task automatic idle_cycle(input logic [31:0] pc);
        drive(1'b0, pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        cyc("idle", 1'b0, 32'h0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        apply_reset();

        // Cold miss with immediate ack and back-to-back beats
        fetch(32'h100, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        // Hits on the filled line, including word 0
        fetch(32'h100, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        fetch(32'h104, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        fetch(32'h108, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        fetch(32'h10C, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        // Slow memory: three REQ cycles before ack, one-cycle beat gaps
        fetch(32'h110, 3, 1, 1, 1'b0, -1, 32'h0, -1);
        fetch(32'h118, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        check_perf("after cold+slow");

        // Redirect during fill: 0x110 completes, then 0x200 is refilled
        fetch(32'h100, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        fetch(32'h110, 1, 0, 1, 1'b0, 1, 32'h200, -1);
        idle_cycle(32'h114);
        fetch(32'h200, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        fetch(32'h20C, 0, 0, 0, 1'b0, -1, 32'h0, -1);

        // Reset after beat 2, stray beats afterwards, then a clean refill
        fetch(32'h100, 0, 0, 0, 1'b0, -1, 32'h0, 2);
        idle_cycle(32'h100);
        idle_cycle(32'h104);
        fetch(32'h100, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        fetch(32'h108, 0, 0, 0, 1'b0, -1, 32'h0, -1);
        check_perf("after reset");

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle(rand_pc());
            end else begin
                fetch(rand_pc(), $urandom_range(0, 3), 0, 2, 1'b1,
                      $urandom_range(0, 7), rand_pc(), -1);
            end
        end
        check_perf("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_imem_fetch_ctrl

`default_nettype wire
